// File: rtl/dlx_fetch_pkg.sv
// Shared types for the DLX instruction fetch front end.
// Fetch FSM states, buffer entry layout and address helpers.
package dlx_fetch_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } fetch_state_t;

  localparam int          WORD_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0020;

  // instr keeps the SRAM's big-endian [0:31] numbering
  typedef struct packed {
    logic [0:31] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sram_fetch_ctrl_if.sv
// SRAM read bus plus decode-side valid/ready handshake
// and branch redirect, as seen by the fetch controller.
interface sram_fetch_ctrl_if;

  logic        mem_cs;
  logic        mem_oe;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [0:31] mem_dout;

  logic        redirect;
  logic [31:0] redirect_pc;

  logic        instr_valid;
  logic        instr_ready;
  logic [0:31] instr;
  logic [31:0] instr_pc;

  modport master (
    output mem_cs,
    output mem_oe,
    output mem_we,
    output mem_addr,
    output mem_din,
    input  mem_dout,
    input  redirect,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc
  );

  modport slave (
    input  mem_cs,
    input  mem_oe,
    input  mem_we,
    input  mem_addr,
    input  mem_din,
    output mem_dout,
    output redirect,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc
  );

endinterface

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {instr, pc} entries.
// Flush wins over push/pop; push and pop may coincide.
module fetch_buffer
  import dlx_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic          do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = mem[rd];

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      mem[wr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wr <= wr + AW'(1);
      end
      if (do_pop) begin
        rd <= rd + AW'(1);
      end
      unique case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_fetch_ctrl.sv
// Instruction fetch initiator: sequential SRAM word reads with
// wait states, buffered and handed to decode via valid/ready.
module sram_fetch_ctrl
  import dlx_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          WAIT_STATES = 1,
  parameter int          DEPTH       = 2
) (
  input logic              clk,
  input logic              reset,
  sram_fetch_ctrl_if.master bus
);

  localparam int            CW     = $clog2(DEPTH) + 1;
  localparam logic [3:0]    WS     = 4'(WAIT_STATES);
  localparam logic [CW-1:0] DEP    = CW'(DEPTH);
  localparam logic [CW-1:0] DEP_M1 = CW'(DEPTH - 1);

  fetch_state_t  state;
  fetch_state_t  state_d;
  logic [31:0]   fetch_pc;
  logic [31:0]   pc_d;
  logic [31:0]   addr_q;
  logic [31:0]   addr_d;
  logic          cs_q;
  logic          cs_d;
  logic [3:0]    cnt_q;
  logic [3:0]    cnt_d;

  logic          push;
  logic          pop;
  logic          flush;
  logic [CW-1:0] count;
  logic          empty;
  logic          room_now;
  logic          room_after;
  logic [31:0]   pc_next;
  fetch_entry_t  din;
  fetch_entry_t  head;

  assign pop     = !empty && bus.instr_ready;
  assign flush   = bus.redirect;
  assign pc_next = fetch_pc + 32'(WORD_BYTES);

  // room_after: space left once this cycle's push and pop land
  assign room_now   = (count < DEP) || pop;
  assign room_after = pop ? (count < DEP) : (count < DEP_M1);

  assign din.instr = bus.mem_dout;
  assign din.pc    = addr_q;

  always_comb begin
    state_d = state;
    pc_d    = fetch_pc;
    addr_d  = addr_q;
    cs_d    = cs_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (bus.redirect) begin
      pc_d    = word_align(bus.redirect_pc);
      addr_d  = word_align(bus.redirect_pc);
      state_d = ACCESS;
      cs_d    = 1'b1;
      cnt_d   = WS;
    end else begin
      unique case (state)
        IDLE: begin
          if (room_now) begin
            state_d = ACCESS;
            cs_d    = 1'b1;
            addr_d  = fetch_pc;
            cnt_d   = WS;
          end
        end
        ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            push = 1'b1;
            pc_d = pc_next;
            if (room_after) begin
              addr_d = pc_next;
              cnt_d  = WS;
            end else begin
              state_d = IDLE;
              cs_d    = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
      cs_q     <= 1'b0;
      cnt_q    <= 4'd0;
    end else begin
      state    <= state_d;
      fetch_pc <= pc_d;
      addr_q   <= addr_d;
      cs_q     <= cs_d;
      cnt_q    <= cnt_d;
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .head  (head),
    .count (count),
    .empty (empty)
  );

  assign bus.mem_cs      = cs_q;
  assign bus.mem_oe      = cs_q;
  assign bus.mem_we      = 1'b0;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_din     = '0;
  assign bus.instr_valid = !empty;
  assign bus.instr       = empty ? '0 : head.instr;
  assign bus.instr_pc    = empty ? '0 : head.pc;

endmodule

// File: tb/tb_sram_fetch_ctrl.sv
// Bench for sram_fetch_ctrl: two configurations share stimulus
// and are compared cycle by cycle with a queue-level model.
module tb_sram_fetch_ctrl;
  import dlx_fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0040_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ready = 1'b0;
  bit          chk_en = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    case (a)
      32'h0040_0020: return 32'h2001_AAAA;
      32'h0040_0024: return 32'h0001_1026;
      32'h0040_0028: return 32'h2822_0A0A;
      32'h0040_002C: return 32'h1440_FFEC;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  sram_fetch_ctrl_if b0();
  sram_fetch_ctrl_if b1();

  assign b0.redirect    = redirect;
  assign b0.redirect_pc = redirect_pc;
  assign b0.instr_ready = ready;
  assign b0.mem_dout    = sram_word(b0.mem_addr);
  assign b1.redirect    = redirect;
  assign b1.redirect_pc = redirect_pc;
  assign b1.instr_ready = ready;
  assign b1.mem_dout    = sram_word(b1.mem_addr);

  sram_fetch_ctrl #(
    .RESET_PC    (RPC),
    .WAIT_STATES (1),
    .DEPTH       (2)
  ) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  sram_fetch_ctrl #(
    .RESET_PC    (RPC),
    .WAIT_STATES (0),
    .DEPTH       (4)
  ) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model: instance k -> wait states, depth, fetch pc, access state,
  // and a ring of buffered {instr, pc}
  int          ws[2]  = '{1, 0};
  int          dep[2] = '{2, 4};
  logic [31:0] m_pc[2];
  logic [31:0] m_addr[2];
  bit          m_busy[2];
  int          m_left[2];
  logic [31:0] q_i[2][8];
  logic [31:0] q_p[2][8];
  int          q_h[2];
  int          q_n[2];

  task automatic model_step(input int k);
    bit pop;
    bit room;
    int t;
    if (reset) begin
      q_n[k] = 0; q_h[k] = 0; m_pc[k] = RPC;
      m_addr[k] = RPC; m_busy[k] = 0; m_left[k] = 0;
      return;
    end
    pop = (q_n[k] > 0) && ready;
    if (redirect) begin
      q_n[k] = 0;
      m_pc[k] = {redirect_pc[31:2], 2'b00};
      m_addr[k] = m_pc[k]; m_busy[k] = 1; m_left[k] = ws[k];
      return;
    end
    room = (q_n[k] < dep[k]) || pop;
    if (pop) begin
      q_h[k] = (q_h[k] + 1) % 8;
      q_n[k]--;
    end
    if (!m_busy[k]) begin
      if (room) begin
        m_busy[k] = 1; m_addr[k] = m_pc[k]; m_left[k] = ws[k];
      end
    end else if (m_left[k] > 0) begin
      m_left[k]--;
    end else begin
      t = (q_h[k] + q_n[k]) % 8;
      q_i[k][t] = sram_word(m_addr[k]);
      q_p[k][t] = m_addr[k];
      q_n[k]++;
      m_pc[k] = m_pc[k] + 32'd4;
      if (q_n[k] < dep[k]) begin
        m_addr[k] = m_pc[k]; m_left[k] = ws[k];
      end else begin
        m_busy[k] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic check_dut(input int k, input logic cs, input logic oe,
                           input logic we, input logic [31:0] addr,
                           input logic [31:0] din, input logic valid,
                           input logic [31:0] ins, input logic [31:0] ipc);
    bit ev;
    ev = q_n[k] > 0;
    chk($sformatf("u%0d.mem_cs", k), 32'(cs), 32'(m_busy[k]));
    chk($sformatf("u%0d.mem_oe", k), 32'(oe), 32'(m_busy[k]));
    chk($sformatf("u%0d.mem_we", k), 32'(we), 32'd0);
    chk($sformatf("u%0d.mem_din", k), din, 32'd0);
    chk($sformatf("u%0d.mem_addr", k), addr, m_addr[k]);
    chk($sformatf("u%0d.valid", k), 32'(valid), 32'(ev));
    chk($sformatf("u%0d.instr", k), ins, ev ? q_i[k][q_h[k]] : 32'd0);
    chk($sformatf("u%0d.instr_pc", k), ipc, ev ? q_p[k][q_h[k]] : 32'd0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_dut(0, b0.mem_cs, b0.mem_oe, b0.mem_we, b0.mem_addr,
                b0.mem_din, b0.instr_valid, b0.instr, b0.instr_pc);
      check_dut(1, b1.mem_cs, b1.mem_oe, b1.mem_we, b1.mem_addr,
                b1.mem_din, b1.instr_valid, b1.instr, b1.instr_pc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int lat0;
    int lat1;
    tick();
    chk_en = 1'b1;

    // sequential fetch with decode always ready
    ready = 1'b1;
    do_reset();
    lat0 = -1;
    lat1 = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (lat0 < 0 && b0.instr_valid) begin
        lat0 = n;
        chk("first.instr", b0.instr, 32'h2001_AAAA);
        chk("first.pc", b0.instr_pc, RPC);
      end
      if (lat1 < 0 && b1.instr_valid) lat1 = n;
      if (lat0 >= 0 && lat1 >= 0) break;
    end
    chk("latency.ws1", lat0, 32'd3);
    chk("latency.ws0", lat1, 32'd2);
    repeat (12) tick();

    // decode stalled: buffer fills, SRAM goes quiet, then resumes
    ready = 1'b0;
    do_reset();
    repeat (12) tick();
    chk("stall.cs", 32'(b0.mem_cs), 32'd0);
    chk("stall.valid", 32'(b0.instr_valid), 32'd1);
    ready = 1'b1;
    tick();
    chk("resume.cs", 32'(b0.mem_cs), 32'd1);
    chk("resume.addr", b0.mem_addr, 32'h0040_0028);
    repeat (8) tick();

    // redirect with one entry buffered and a read in flight
    ready = 1'b0;
    do_reset();
    for (int n = 0; n < 20; n++) begin
      if (b0.instr_valid && b0.mem_cs) break;
      tick();
    end
    chk("redir.setup", 32'(b0.instr_valid && b0.mem_cs), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h0040_0022;
    tick();
    redirect = 1'b0;
    chk("redir.valid", 32'(b0.instr_valid), 32'd0);
    chk("redir.addr", b0.mem_addr, 32'h0040_0020);
    chk("redir.cs", 32'(b0.mem_cs), 32'd1);
    ready = 1'b1;
    repeat (8) tick();

    // zero wait states: one word per cycle through the address wrap
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF3;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("stream.addr%0d", i), b1.mem_addr,
          32'hFFFF_FFF0 + 32'(4 * i));
      if (i > 0) chk($sformatf("stream.valid%0d", i),
                     32'(b1.instr_valid), 32'd1);
      tick();
    end

    // reset while buffer is full
    ready = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    chk("rst.cs", 32'(b0.mem_cs), 32'd0);
    chk("rst.valid", 32'(b0.instr_valid), 32'd0);
    chk("rst.addr", b0.mem_addr, RPC);
    chk("rst1.valid", 32'(b1.instr_valid), 32'd0);
    reset = 1'b0;

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_pc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
      else
        redirect_pc = $urandom();
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    redirect = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
